stream_sequencer: RTL
=====================

# stream_sequencer

Frame-level controller that sits between the pixel source and the detection datapath (grayscale, Sobel window, threshold, connected components, colour lookup). It generates the datapath's global `en` from a valid/ready handshake and regenerates `hsync`/`vsync` aligned to accepted pixels. It latches the display mode once per frame and drains the pipeline with bubble pixels at end of frame. It also asserts `out_valid` only on cycles whose datapath output corresponds to a real input pixel.

## Interface
- `FRAME_WIDTH`, 640, pixels per row (≥2)
- `FRAME_HEIGHT`, 480, rows per frame (≥1)
- `LATENCY`, 2*FRAME_WIDTH+4, en-cycles from a pixel entering the datapath to its result at datapath `out`
- `WORD_SIZE`, 8, width of mode word
- `clk` in 1: single clock; all state changes on its rising edge
- `reset_n` in 1: reset is asynchronous and active-low
- `in_valid` in 1: source pixel present
- `in_vsync` in 1: qualifies the current source pixel as first of a frame
- `in_ready` out 1: pixel accepted when `in_valid & in_ready`
- `out_ready` in 1: sink can take a result this cycle
- `mode_req` in WORD_SIZE: requested output mode
- `en` out 1: datapath advance (combinational)
- `dp_hsync` out 1: to datapath, high on en-cycle of column 0
- `dp_vsync` out 1: to datapath, high on en-cycle of pixel 0 of frame
- `dp_bubble` out 1: datapath input muxes to zero pixel
- `mode` out WORD_SIZE: active mode to datapath output mux
- `out_valid` out 1: datapath `out` is a real result this cycle
- `frame_done` out 1: one-cycle pulse, frame fully drained
- `frame_err` out 1: one-cycle pulse, `in_vsync` seen mid-frame

## Operation
- FSM states: IDLE, RUN, DRAIN.
- Counters:
  - `col` (0..W-1)
  - `pix` (0..W*H-1)
  - `fill` (saturating 0..LATENCY, counts en-cycles in frame)
  - `drn` (0..LATENCY-1)
  - Widths are $clog2 of range; no wrap other than listed.
- IDLE:
  - `in_ready`=1.
  - Pixels without `in_vsync` are accepted and discarded, with `en`=0.
  - Accepted pixel with `in_vsync`:
    - `en`=1, `dp_vsync`=`dp_hsync`=1.
    - `mode` <= `mode_req`.
    - `col`<=1, `pix`<=1, `fill`<=1.
    - Go to RUN.
- RUN:
  - `in_ready = (fill < LATENCY) | out_ready`.
  - `en = in_valid & in_ready & ~in_vsync`.
  - Each en: `col` advances, wrapping W-1→0; `pix`++; `fill` saturates.
  - `dp_hsync` = (`col`==0) & `en`; `dp_vsync`=0.
  - Accept of pixel W*H-1 → DRAIN, `drn`<=0.
  - `in_valid & in_vsync` in RUN:
    - `frame_err` pulses.
    - The pixel is treated as a new start of frame exactly as in IDLE: `en`=1, counters restart, `mode` relatched, in-flight results abandoned.
    - `in_ready`=1 for it regardless of `out_ready`.
- DRAIN:
  - `in_ready`=0, `dp_bubble`=1, `en = out_ready`.
  - Each en: `drn`++ and `fill` stays saturated.
  - On en with `drn`==LATENCY-1: `frame_done` pulses and FSM goes to IDLE.
- `out_valid = en & (fill ≥ LATENCY)`, using pre-increment `fill`. This yields exactly W*H valid results per frame.
- `mode` changes only at start-of-frame acceptance; `mode_req` ignored otherwise.

## Timing
- Reset values:
  - State IDLE; all counters 0; `mode`=0.
  - `frame_done`=`frame_err`=0.
  - Combinational outputs follow: `en`=0, `in_ready`=1, `out_valid`=0, `dp_*`=0.
- `en`, `in_ready`, `out_valid`, `dp_hsync`, `dp_vsync`, `dp_bubble` are combinational from state and inputs, with no added cycle.
- `frame_done` and `frame_err` are registered: high the cycle after the triggering en-cycle, for one cycle.
- Result latency: pixel k accepted on en-cycle k; its result appears with `out_valid` on en-cycle k+LATENCY.
- Stall:
  - `out_ready`=0 while `fill`==LATENCY freezes the datapath (`en`=0). No result is lost or duplicated.
  - `in_valid`=0 likewise freezes it.
- Back-to-back frames: the next frame's vsync pixel is not accepted until IDLE, at least one cycle after the last drain en.
- Reset mid-frame: immediate return to IDLE; partial results are not flagged; no `frame_done`.

## Test plan
- Params W=4, H=2, LATENCY=5. Stream 8 pixels, first with `in_vsync`, `in_valid`/`out_ready` held 1:
  - `en` high for 13 consecutive cycles.
  - `out_valid` high on en-cycles 5..12.
  - `dp_bubble` on en-cycles 8..12.
  - `dp_hsync` on en-cycles 0 and 4; `dp_vsync` on en-cycle 0.
  - `frame_done` one cycle after the 13th en.
- Idle garbage: 3 pixels without vsync in IDLE → `in_ready`=1, `en`=0; first vsync pixel then starts frame.
- Backpressure: drop `out_ready` for 3 cycles at en-cycle 7 → `en`,`in_ready` low those cycles; total `out_valid` count still 8, in order.
- Mode: `mode_req`=3 at SOF, changed to 5 mid-frame → `mode` stays 3 until next SOF accept, then 5.
- Mid-frame vsync at pixel 3 → `frame_err` pulse; `fill`, `col` and `pix` restart (`col` and `pix` to 1); 8 further pixels produce 8 `out_valid`; one `frame_done`.
- Assert `reset_n`=0 during DRAIN → outputs at reset values immediately; no `frame_done`.

Source files
------------

// File: rtl/stream_sequencer.sv
// Frame sequencer: drives datapath en, syncs and mode from a valid/ready pixel stream; en/in_ready/out_valid are combinational.
// Stalls the datapath when a filled pipe meets out_ready=0; frame_done/frame_err pulse one cycle after their en-cycle.
module stream_sequencer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int LATENCY      = 2*FRAME_WIDTH+4,
  parameter int WORD_SIZE    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 in_vsync,
  output logic                 in_ready,
  input  logic                 out_ready,
  input  logic [WORD_SIZE-1:0] mode_req,
  output logic                 en,
  output logic                 dp_hsync,
  output logic                 dp_vsync,
  output logic                 dp_bubble,
  output logic [WORD_SIZE-1:0] mode,
  output logic                 out_valid,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam int NPIX = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int CW   = $clog2(FRAME_WIDTH);
  localparam int PW   = $clog2(NPIX);
  localparam int FW   = $clog2(LATENCY + 1);
  localparam int DW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(LATENCY);
  localparam logic [DW-1:0] DRN_LAST = DW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [PW-1:0] pix;
  logic [FW-1:0] fill;
  logic [DW-1:0] drn;

  logic sof;
  logic run_en;
  logic drain_en;
  logic filled;

  // A vsync pixel always restarts the frame, even mid-frame, so it bypasses backpressure.
  always_comb begin
    sof       = 1'b0;
    run_en    = 1'b0;
    drain_en  = 1'b0;
    in_ready  = 1'b0;
    dp_bubble = 1'b0;
    filled    = (fill >= FILL_MAX);
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        sof      = in_valid & in_vsync;
      end
      RUN: begin
        sof      = in_valid & in_vsync;
        in_ready = sof | ~filled | out_ready;
        run_en   = in_valid & in_ready & ~in_vsync;
      end
      DRAIN: begin
        dp_bubble = 1'b1;
        drain_en  = out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
    en        = sof | run_en | drain_en;
    dp_vsync  = sof;
    dp_hsync  = sof | (run_en & (col == '0));
    // Results still in flight when a frame restarts belong to the abandoned frame.
    out_valid = en & ~sof & filled;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      col        <= '0;
      pix        <= '0;
      fill       <= '0;
      drn        <= '0;
      mode       <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (sof) begin
        frame_err <= (state == RUN);
        state     <= RUN;
        mode      <= mode_req;
        col       <= CW'(1);
        pix       <= PW'(1);
        fill      <= FW'(1);
        drn       <= '0;
      end else if (run_en) begin
        col <= (col == COL_LAST) ? '0 : col + CW'(1);
        pix <= pix + PW'(1);
        if (!filled) begin
          fill <= fill + FW'(1);
        end
        if (pix == PIX_LAST) begin
          state <= DRAIN;
          drn   <= '0;
        end
      end else if (drain_en) begin
        if (drn == DRN_LAST) begin
          state      <= IDLE;
          frame_done <= 1'b1;
        end else begin
          drn <= drn + DW'(1);
        end
      end
    end
  end

endmodule
